// File: rtl/branch_pred_ctrl.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by PC.
// Each lookup returns a registered direction and valid bit one cycle later.
// Feedback from the branch unit trains the table and updates the hit/miss counters.
// Valid/ready note: there is no back-pressure. A lookup_v_i or fb_v_i pulse is
// consumed on the clock edge where it is high; pred_v_o is valid for one cycle.
module branch_pred_ctrl #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int IDX_LSB   = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            pred_en_i,
    input  logic            lookup_v_i,
    input  logic [XLEN-1:0] lookup_pc_i,
    input  logic            flush_i,
    output logic            pred_v_o,
    output logic            pred_is_taken_o,
    input  logic            fb_v_i,
    input  logic [XLEN-1:0] fb_pc_i,
    input  logic            fb_taken_i,
    input  logic            fb_success_i,
    input  logic            fb_failed_i,
    input  logic            clear_stats_i,
    output logic [XLEN-1:0] hit_cnt_o,
    output logic [XLEN-1:0] miss_cnt_o
);
    localparam int IW = $clog2(BHT_DEPTH);

    logic [1:0]           ctr_q [BHT_DEPTH];
    logic [BHT_DEPTH-1:0] valid_q;
    logic                 pred_v_q, pred_v_d;
    logic                 pred_t_q, pred_t_d;
    logic [XLEN-1:0]      hit_q, hit_d;
    logic [XLEN-1:0]      miss_q, miss_d;

    logic [IW-1:0] lk_idx, fb_idx;
    logic [1:0]    fb_ctr_cur, fb_ctr_new, lk_ctr;
    logic          lk_valid, same_idx;

    // Only the index bits of the PCs are used; the rest are folded here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc_i, fb_pc_i};

    assign lk_idx = lookup_pc_i[IDX_LSB +: IW];
    assign fb_idx = fb_pc_i[IDX_LSB +: IW];

    // Saturating counter update and same-index bypass so a lookup sees the trained value.
    always_comb begin
        fb_ctr_cur = ctr_q[fb_idx];
        fb_ctr_new = fb_ctr_cur;
        if (fb_taken_i) begin
            if (fb_ctr_cur != 2'b11) fb_ctr_new = fb_ctr_cur + 2'b01;
        end else begin
            if (fb_ctr_cur != 2'b00) fb_ctr_new = fb_ctr_cur - 2'b01;
        end
        same_idx = fb_v_i && (fb_idx == lk_idx);
        lk_ctr   = same_idx ? fb_ctr_new : ctr_q[lk_idx];
        lk_valid = same_idx | valid_q[lk_idx];
    end

    // Next prediction: killed by flush or by no lookup; valid also gated by enable.
    always_comb begin
        pred_v_d = 1'b0;
        pred_t_d = 1'b0;
        if (lookup_v_i && !flush_i) begin
            pred_v_d = pred_en_i & lk_valid;
            pred_t_d = lk_ctr[1];
        end
    end

    // Perf counters: clear wins, a failed feedback is a miss even if success is also set.
    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (clear_stats_i) begin
            hit_d  = '0;
            miss_d = '0;
        end else if (fb_v_i) begin
            if (fb_failed_i) begin
                if (miss_q != '1) miss_d = miss_q + 1'b1;
            end else if (fb_success_i) begin
                if (hit_q != '1) hit_d = hit_q + 1'b1;
            end
        end
    end

    // Predictor table: reset to weak not-taken, untrained; train one entry per feedback.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) ctr_q[i] <= 2'b01;
            valid_q <= '0;
        end else if (fb_v_i) begin
            ctr_q[fb_idx]   <= fb_ctr_new;
            valid_q[fb_idx] <= 1'b1;
        end
    end

    // Output and statistics registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred_v_q <= 1'b0;
            pred_t_q <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            pred_v_q <= pred_v_d;
            pred_t_q <= pred_t_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

    assign pred_v_o        = pred_v_q;
    assign pred_is_taken_o = pred_t_q;
    assign hit_cnt_o       = hit_q;
    assign miss_cnt_o      = miss_q;
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed and randomised checks of branch_pred_ctrl against a small reference model.
module tb_branch_pred_ctrl;
    // ---------------- clock / reset and DUT signals
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pred_en, lookup_v, flush, fb_v, fb_taken, fb_succ, fb_fail, clr;
    logic [31:0] lookup_pc, fb_pc;
    logic        pred_v, pred_t;
    logic [31:0] hit_cnt, miss_cnt;

    // narrow instance used to reach counter saturation in a short run
    logic        s_fb_v, s_succ, s_fail;
    logic        s_pred_v, s_pred_t;
    logic [7:0]  s_hit, s_miss;

    always #5 clk = ~clk;

    branch_pred_ctrl dut (
        .clk(clk), .reset_n(reset_n), .pred_en_i(pred_en), .lookup_v_i(lookup_v),
        .lookup_pc_i(lookup_pc), .flush_i(flush), .pred_v_o(pred_v),
        .pred_is_taken_o(pred_t), .fb_v_i(fb_v), .fb_pc_i(fb_pc), .fb_taken_i(fb_taken),
        .fb_success_i(fb_succ), .fb_failed_i(fb_fail), .clear_stats_i(clr),
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    branch_pred_ctrl #(.XLEN(8)) u_small (
        .clk(clk), .reset_n(reset_n), .pred_en_i(1'b1), .lookup_v_i(1'b0),
        .lookup_pc_i(8'h00), .flush_i(1'b0), .pred_v_o(s_pred_v),
        .pred_is_taken_o(s_pred_t), .fb_v_i(s_fb_v), .fb_pc_i(8'h00), .fb_taken_i(1'b0),
        .fb_success_i(s_succ), .fb_failed_i(s_fail), .clear_stats_i(1'b0),
        .hit_cnt_o(s_hit), .miss_cnt_o(s_miss)
    );

    // ---------------- reference model and scoreboard
    logic [1:0]  ctr_m [64];
    logic        val_m [64];
    logic [31:0] hit_m, miss_m;
    logic [1:0]  exp_q [$];
    logic [63:0] cnt_q [$];
    int          tests = 0;
    int          fails = 0;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            ctr_m[i] = 2'b01;
            val_m[i] = 1'b0;
        end
        hit_m  = '0;
        miss_m = '0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one clock of stimulus, model update, then compare
    task automatic cyc(input string tag, input logic lv, input logic [31:0] lpc,
                       input logic fv, input logic [31:0] fpc, input logic ft,
                       input logic fs, input logic ff, input logic fl,
                       input logic en, input logic cl);
        int       fi, li;
        logic     pv, pt;
        logic [1:0] exp_p;
        logic [63:0] exp_c;
        lookup_v = lv; lookup_pc = lpc; fb_v = fv; fb_pc = fpc; fb_taken = ft;
        fb_succ = fs; fb_fail = ff; flush = fl; pred_en = en; clr = cl;
        fi = int'(fpc[2 +: 6]);
        li = int'(lpc[2 +: 6]);
        // training applied first: a same-cycle lookup observes the trained entry
        if (fv) begin
            val_m[fi] = 1'b1;
            if (ft) ctr_m[fi] = (ctr_m[fi] == 2'b11) ? 2'b11 : ctr_m[fi] + 2'b01;
            else    ctr_m[fi] = (ctr_m[fi] == 2'b00) ? 2'b00 : ctr_m[fi] - 2'b01;
        end
        pv = 1'b0; pt = 1'b0;
        if (lv && !fl) begin
            pv = en & val_m[li];
            pt = ctr_m[li][1];
        end
        if (cl) begin
            hit_m = '0; miss_m = '0;
        end else if (fv) begin
            if (ff) begin
                if (miss_m != '1) miss_m = miss_m + 1;
            end else if (fs) begin
                if (hit_m != '1) hit_m = hit_m + 1;
            end
        end
        exp_q.push_back({pv, pt});
        cnt_q.push_back({hit_m, miss_m});
        @(posedge clk);
        #1;
        exp_p = exp_q.pop_front();
        exp_c = cnt_q.pop_front();
        check({tag, "_pred"}, {62'd0, pred_v, pred_t}, {62'd0, exp_p});
        check({tag, "_cnt"}, {hit_cnt, miss_cnt}, exp_c);
    endtask

    task automatic look(input string tag, input logic [31:0] pc);
        cyc(tag, 1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic train(input string tag, input logic [31:0] pc, input logic t);
        cyc(tag, 1'b0, 32'h0, 1'b1, pc, t, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic stat(input string tag, input logic fv, input logic fs, input logic ff,
                        input logic cl);
        cyc(tag, 1'b0, 32'h0, fv, 32'h0000_0300, 1'b1, fs, ff, 1'b0, 1'b1, cl);
    endtask

    // ---------------- directed sequence
    initial begin
        pred_en = 1'b1; lookup_v = 1'b0; lookup_pc = '0; flush = 1'b0; fb_v = 1'b0;
        fb_pc = '0; fb_taken = 1'b0; fb_succ = 1'b0; fb_fail = 1'b0; clr = 1'b0;
        s_fb_v = 1'b0; s_succ = 1'b0; s_fail = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {pred_v, pred_t, hit_cnt, miss_cnt}, 66'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: nothing trained after reset
        look("untrained_100", 32'h100);
        for (int i = 0; i < 64; i++) look("untrained_all", 32'(i) << 2);

        // 2: training, saturation at 00 and 11, aliasing
        train("t_100_a", 32'h100, 1'b1);
        look("lk_100_taken", 32'h100);
        train("t_100_b", 32'h100, 1'b0);
        train("t_100_c", 32'h100, 1'b0);
        look("lk_100_nt", 32'h100);
        train("t_100_d", 32'h100, 1'b0);
        look("lk_100_sat0", 32'h100);
        train("t_100_e", 32'h100, 1'b1);
        look("lk_100_after_sat0", 32'h100);
        look("alias_200", 32'h200);
        for (int i = 0; i < 4; i++) train("t_180", 32'h180, 1'b1);
        train("t_180_nt", 32'h180, 1'b0);
        look("lk_180_sat3", 32'h180);
        look("neighbour_104", 32'h104);

        // 3: same-cycle lookup and train on a fresh entry
        cyc("bypass_40", 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        look("lk_40", 32'h40);

        // 4: flush and disable
        train("t_100_f", 32'h100, 1'b1);
        cyc("flush", 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        look("after_flush", 32'h100);
        cyc("disabled", 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("flush_trains", 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        look("lk_80_trained", 32'h80);

        // 5: performance counters
        for (int i = 0; i < 3; i++) stat("hit", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) stat("miss", 1'b1, 1'b0, 1'b1, 1'b0);
        stat("both_set", 1'b1, 1'b1, 1'b1, 1'b0);
        stat("no_fb_v", 1'b0, 1'b1, 1'b1, 1'b0);
        stat("clear_with_fb", 1'b1, 1'b0, 1'b1, 1'b1);

        // random mix over a small index range
        for (int i = 0; i < 300; i++) begin
            cyc("rand", 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
                1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 7) != 0), ($urandom_range(0, 39) == 0));
        end

        // saturation of both counters on the 8-bit instance
        s_fb_v = 1'b1; s_fail = 1'b1;
        repeat (270) @(posedge clk);
        #1;
        check("miss_sat", {56'd0, s_miss}, 64'hFF);
        check("hit_untouched", {56'd0, s_hit}, 64'h0);
        s_fail = 1'b0; s_succ = 1'b1;
        repeat (270) @(posedge clk);
        #1;
        check("hit_sat", {56'd0, s_hit, s_miss}, 64'hFFFF);
        s_fb_v = 1'b0; s_succ = 1'b0;

        // 6: asynchronous reset between edges
        stat("pre_reset_hit", 1'b1, 1'b1, 1'b0, 1'b0);
        look("pre_reset", 32'h100);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {pred_v, pred_t, hit_cnt, miss_cnt}, 66'd0);
        #2;
        reset_n = 1'b1;
        model_reset();
        look("post_reset_100", 32'h100);
        look("post_reset_80", 32'h80);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
